crypto_rsa_engine: RTL and testbench

Parametrised successor to the fixed 32-bit RSA top level. It holds a public exponent, a private exponent and a modulus, and performs either encryption or decryption on one word per request. Work is done with an internal right-to-left square-and-multiply exponentiator built from two bit-serial interleaved modular multipliers. The block adds a start/busy/done handshake, mode select, operand range checking and a deterministic latency.

---
 rtl/crypto_rsa_engine_if.sv | 27 ++
 rtl/crypto_rsa_engine.sv | 136 +++++++++++++
 tb/tb_crypto_rsa_engine.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/crypto_rsa_engine_if.sv
// Request/response bus of the RSA engine: key load, operation start and result.
// The master side issues keys and requests; the slave side is the engine.
interface crypto_rsa_engine_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pub_key;
  logic [WIDTH-1:0] priv_key;
  logic [WIDTH-1:0] n;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             mode;
  logic             start;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] data_out;

  modport master (
    output pub_key, priv_key, n, load, data_in, mode, start,
    input  busy, done, error, data_out
  );

  modport slave (
    input  pub_key, priv_key, n, load, data_in, mode, start,
    output busy, done, error, data_out
  );
endinterface

// File: rtl/crypto_rsa_engine.sv
// Modular exponentiation engine: right-to-left square-and-multiply using two
// bit-serial interleaved modular multipliers; fixed latency of WIDTH^2+3 edges.
module crypto_rsa_engine #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  crypto_rsa_engine_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = WIDTH + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] e_reg, d_reg, n_reg;
  logic [WIDTH-1:0] data_reg, exp_reg;
  logic [WIDTH-1:0] result_reg, base_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic [CW-1:0]    bit_reg, cnt_reg;
  logic             err_reg, error_reg, done_reg;
  logic [PW-1:0]    p_reg  [2];
  logic [PW-1:0]    p_next [2];
  logic [WIDTH-1:0] mul_a  [2];
  logic [PW-1:0]    n_ext, b_ext;
  logic             busy;
  logic             start_ok, load_ok;

  // The done cycle still counts as busy, so nothing is accepted until it is over.
  assign busy     = (state_reg != S_IDLE) || done_reg;
  assign start_ok = bus.start && !busy;
  assign load_ok  = bus.load && !busy;

  assign bus.busy     = busy;
  assign bus.done     = done_reg;
  assign bus.error    = error_reg;
  assign bus.data_out = data_out_reg;

  assign n_ext    = {2'b00, n_reg};
  assign b_ext    = {2'b00, base_reg};
  assign mul_a[0] = result_reg;   // M1: result * base
  assign mul_a[1] = base_reg;     // M2: base * base

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mul
      logic [PW-1:0] dbl_raw, dbl, sum;
      assign dbl_raw    = p_reg[gi] << 1;
      assign dbl        = (dbl_raw >= n_ext) ? dbl_raw - n_ext : dbl_raw;
      assign sum        = mul_a[gi][cnt_reg] ? dbl + b_ext : dbl;
      assign p_next[gi] = (sum >= n_ext) ? sum - n_ext : sum;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      e_reg        <= '0;
      d_reg        <= '0;
      n_reg        <= '0;
      data_reg     <= '0;
      exp_reg      <= '0;
      result_reg   <= '0;
      base_reg     <= '0;
      data_out_reg <= '0;
      bit_reg      <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      error_reg    <= 1'b0;
      done_reg     <= 1'b0;
      p_reg[0]     <= '0;
      p_reg[1]     <= '0;
    end else begin
      done_reg <= 1'b0;
      if (load_ok) begin
        e_reg <= bus.pub_key;
        d_reg <= bus.priv_key;
        n_reg <= bus.n;
      end
      case (state_reg)
        S_IDLE: begin
          if (start_ok) begin
            data_reg  <= bus.data_in;
            // A simultaneous load must feed the exponent chosen for this start.
            if (bus.mode)
              exp_reg <= load_ok ? bus.priv_key : d_reg;
            else
              exp_reg <= load_ok ? bus.pub_key : e_reg;
            error_reg <= 1'b0;
            state_reg <= S_CHECK;
          end
        end
        S_CHECK: begin
          if ((n_reg < WIDTH'(2)) || (data_reg >= n_reg)) begin
            err_reg   <= 1'b1;
            state_reg <= S_FINISH;
          end else begin
            err_reg    <= 1'b0;
            result_reg <= WIDTH'(1);
            base_reg   <= data_reg;
            bit_reg    <= '0;
            cnt_reg    <= CW'(WIDTH - 1);
            p_reg[0]   <= '0;
            p_reg[1]   <= '0;
            state_reg  <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_reg == '0) begin
            base_reg <= p_next[1][WIDTH-1:0];
            if (exp_reg[bit_reg])
              result_reg <= p_next[0][WIDTH-1:0];
            p_reg[0] <= '0;
            p_reg[1] <= '0;
            cnt_reg  <= CW'(WIDTH - 1);
            bit_reg  <= bit_reg + 1'b1;
            if (bit_reg == CW'(WIDTH - 1))
              state_reg <= S_FINISH;
          end else begin
            p_reg   <= p_next;
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          data_out_reg <= err_reg ? '0 : result_reg;
          error_reg    <= err_reg;
          done_reg     <= 1'b1;
          state_reg    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_crypto_rsa_engine.sv
// Scoreboard bench for crypto_rsa_engine at WIDTH=32 and WIDTH=8.
module tb_crypto_rsa_engine;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  crypto_rsa_engine_if #(.WIDTH(32)) bus32 ();
  crypto_rsa_engine_if #(.WIDTH(8))  bus8 ();

  crypto_rsa_engine #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  crypto_rsa_engine #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  logic [32:0] q32 [$];
  logic [8:0]  q8  [$];

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] want);
    n_checks++;
    if (actual !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, want);
    end
  endtask

  function automatic longint unsigned modexp(input longint unsigned b_in,
                                             input longint unsigned e_in,
                                             input longint unsigned m, input int w);
    longint unsigned r, b, e;
    r = 1 % m;
    b = b_in % m;
    e = e_in;
    for (int i = 0; i < w; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r;
  endfunction

  // Monitors: pop an expectation whenever a done pulse appears.
  always @(posedge clk) begin
    logic [32:0] want32;
    #1;
    if (bus32.done === 1'b1) begin
      if (q32.size() == 0) check("done32_unexpected", 1, 0);
      else begin
        want32 = q32.pop_front();
        check("data32", bus32.data_out, want32[31:0]);
        check("error32", bus32.error, want32[32]);
        check("busy32_with_done", bus32.busy, 1);
      end
      $display("done32 data_out=%0d error=%0d", bus32.data_out, bus32.error);
    end
  end

  always @(posedge clk) begin
    logic [8:0] want8;
    #1;
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) check("done8_unexpected", 1, 0);
      else begin
        want8 = q8.pop_front();
        check("data8", bus8.data_out, want8[7:0]);
        check("error8", bus8.error, want8[8]);
      end
      $display("done8 data_out=%0d error=%0d", bus8.data_out, bus8.error);
    end
  end

  task automatic load32(input logic [31:0] nv, input logic [31:0] ev, input logic [31:0] dv);
    bus32.n = nv; bus32.pub_key = ev; bus32.priv_key = dv; bus32.load = 1'b1;
    @(posedge clk); #1;
    bus32.load = 1'b0;
  endtask

  task automatic load8(input logic [7:0] nv, input logic [7:0] ev, input logic [7:0] dv);
    bus8.n = nv; bus8.pub_key = ev; bus8.priv_key = dv; bus8.load = 1'b1;
    @(posedge clk); #1;
    bus8.load = 1'b0;
  endtask

  // side: 0 none, 1 extra start pulse while busy, 2 load pulse while busy
  task automatic op32(input logic m, input logic [31:0] din, input logic [31:0] want,
                      input logic want_err, input int want_lat, input int side);
    int cyc;
    q32.push_back({want_err, want});
    bus32.data_in = din; bus32.mode = m; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    cyc = 1;
    while (bus32.done !== 1'b1 && cyc < 3000) begin
      bus32.start = (side == 1 && cyc == 10);
      bus32.load  = (side == 2 && cyc == 10);
      if (side == 2) begin bus32.n = 32'd5; bus32.pub_key = 32'd3; bus32.priv_key = 32'd3; end
      @(posedge clk); #1;
      cyc++;
    end
    bus32.start = 1'b0;
    bus32.load  = 1'b0;
    $display("op32 mode=%0d data_in=%0d latency=%0d", m, din, cyc);
    check("latency32", cyc, want_lat);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] din, input logic [7:0] want, input int want_lat);
    int cyc;
    q8.push_back({1'b0, want});
    bus8.data_in = din; bus8.mode = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    cyc = 1;
    while (bus8.done !== 1'b1 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    $display("op8 data_in=%0d latency=%0d", din, cyc);
    check("latency8", cyc, want_lat);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus32.pub_key = '0; bus32.priv_key = '0; bus32.n = '0; bus32.load = 1'b0;
    bus32.data_in = '0; bus32.mode = 1'b0; bus32.start = 1'b0;
    bus8.pub_key = '0; bus8.priv_key = '0; bus8.n = '0; bus8.load = 1'b0;
    bus8.data_in = '0; bus8.mode = 1'b0; bus8.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus32.busy, 0);
    check("rst_done", bus32.done, 0);
    check("rst_error", bus32.error, 0);
    check("rst_data_out", bus32.data_out, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    load32(32'd3233, 32'd17, 32'd2753);
    op32(1'b0, 32'd65, 32'd2790, 1'b0, 1027, 0);
    op32(1'b1, 32'd2790, 32'd65, 1'b0, 1027, 1);

    load32(32'd3233, 32'd0, 32'd2753);
    op32(1'b0, 32'd5, 32'd1, 1'b0, 1027, 0);
    load32(32'd3233, 32'd17, 32'd2753);
    op32(1'b0, 32'd0, 32'd0, 1'b0, 1027, 0);
    load32(32'd3233, 32'd1, 32'd2753);
    op32(1'b0, 32'd3232, 32'd3232, 1'b0, 1027, 0);

    op32(1'b0, 32'd3233, 32'd0, 1'b1, 3, 0);
    load32(32'd1, 32'd17, 32'd2753);
    op32(1'b0, 32'd0, 32'd0, 1'b1, 3, 0);

    // Abort an operation with reset; no done may follow.
    load32(32'd3233, 32'd17, 32'd2753);
    bus32.data_in = 32'd65; bus32.mode = 1'b0; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    check("pre_rst_busy", bus32.busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_busy", bus32.busy, 0);
    check("midrst_done", bus32.done, 0);
    check("midrst_error", bus32.error, 0);
    check("midrst_data_out", bus32.data_out, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (1100) @(posedge clk);
    #1;

    load32(32'd3233, 32'd17, 32'd2753);
    op32(1'b0, 32'd65, 32'd2790, 1'b0, 1027, 0);
    op32(1'b0, 32'd65, 32'd2790, 1'b0, 1027, 2);
    bus32.n = 32'd3233; bus32.pub_key = 32'd17; bus32.priv_key = 32'd2753;
    op32(1'b0, 32'd65, 32'd2790, 1'b0, 1027, 0);

    load8(8'd253, 8'd7, 8'd0);
    op8(8'd2, 8'd128, 67);
    load8(8'd253, 8'd255, 8'd0);
    op8(8'd2, 8'(modexp(2, 255, 253, 8)), 67);

    check("q32_drained", q32.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
